// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the IF stage of the pipelined MIPS core.
// Holds the fetch PC and picks the next PC from sequential increment, branch
// redirect, jump redirect, stall hold or halt. Supports continuous-run and
// debug single-step modes, traps misaligned redirect targets and counts
// consumed fetches for the debug unit.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_enable             global stage enable; 0 freezes every register
//   i_start, i_mode_step leave IDLE; mode (1 = single-step, 0 = run)
//   i_step               debug step request pulse
//   i_stall, i_halt      hazard stall (hold PC), halt instruction detected
//   i_branch_taken/addr  branch redirect request and target
//   i_jump/addr          jump redirect request and target
//   o_pc                 current fetch address (registered)
//   o_pc_plus            o_pc + PC_STEP (combinational link value)
//   o_valid              fetch at o_pc consumed this cycle
//   o_halted             state is HALTED
//   o_addr_err           sticky misaligned-redirect flag
//   o_state              IDLE=00, RUN=01, STEP=10, HALTED=11
//   o_fetch_count        saturating count of cycles with o_valid=1
module pc_unit #(
  parameter int unsigned             SIZE_ADDR_PC = 32,
  parameter int unsigned             PC_STEP      = 4,
  parameter logic [SIZE_ADDR_PC-1:0] RESET_ADDR   = '0,
  parameter int unsigned             COUNT_WIDTH  = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_start,
  input  logic                    i_mode_step,
  input  logic                    i_step,
  input  logic                    i_stall,
  input  logic                    i_halt,
  input  logic                    i_branch_taken,
  input  logic [SIZE_ADDR_PC-1:0] i_branch_addr,
  input  logic                    i_jump,
  input  logic [SIZE_ADDR_PC-1:0] i_jump_addr,
  output logic [SIZE_ADDR_PC-1:0] o_pc,
  output logic [SIZE_ADDR_PC-1:0] o_pc_plus,
  output logic                    o_valid,
  output logic                    o_halted,
  output logic                    o_addr_err,
  output logic [1:0]              o_state,
  output logic [COUNT_WIDTH-1:0]  o_fetch_count
);

  localparam logic [1:0] StIdle   = 2'b00;
  localparam logic [1:0] StRun    = 2'b01;
  localparam logic [1:0] StStep   = 2'b10;
  localparam logic [1:0] StHalted = 2'b11;

  localparam logic [SIZE_ADDR_PC-1:0] StepInc   = SIZE_ADDR_PC'(PC_STEP);
  // PC_STEP is a power of two, so the low bits below it must be zero.
  localparam logic [SIZE_ADDR_PC-1:0] AlignMask = SIZE_ADDR_PC'(PC_STEP - 1);

  logic [SIZE_ADDR_PC-1:0] pc_q, pc_d, pc_plus, target;
  logic [1:0]              state_q, state_d;
  logic                    pend_q, pend_d;
  logic                    err_q, err_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    adv, redirect, valid;

  assign pc_plus = pc_q + StepInc;

  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    pend_d   = pend_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    valid    = 1'b0;
    adv      = i_enable && ((state_q == StRun) ||
                            ((state_q == StStep) && (pend_q || i_step)));
    redirect = i_branch_taken || i_jump;
    // Branch wins over a simultaneous jump.
    target   = i_branch_taken ? i_branch_addr : i_jump_addr;

    if (i_enable) begin
      case (state_q)
        StIdle: begin
          if (i_start) state_d = i_mode_step ? StStep : StRun;
        end
        StRun, StStep: begin
          // A step blocked by a stall stays pending; repeated pulses collapse.
          if ((state_q == StStep) && i_step) pend_d = 1'b1;
          if (adv) begin
            if (i_halt) begin
              state_d = StHalted;
              pend_d  = 1'b0;
            end else if (redirect) begin
              if ((target & AlignMask) != '0) begin
                err_d   = 1'b1;
                state_d = StHalted;
                pend_d  = 1'b0;
              end else begin
                pc_d   = target;
                valid  = 1'b1;
                pend_d = 1'b0;
              end
            end else if (!i_stall) begin
              pc_d   = pc_plus;
              valid  = 1'b1;
              pend_d = 1'b0;
            end
          end
        end
        default: ;  // HALTED: everything holds until reset
      endcase
    end

    if (valid && !(&cnt_q)) cnt_d = cnt_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q    <= RESET_ADDR;
      state_q <= StIdle;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (i_enable) begin
      pc_q    <= pc_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_pc_plus     = pc_plus;
  assign o_valid       = valid;
  assign o_halted      = (state_q == StHalted);
  assign o_addr_err    = err_q;
  assign o_state       = state_q;
  assign o_fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed vector table for run mode plus hand-written
// sequences for single-step, misaligned redirect and an 8-bit wrap/saturation
// instance.
module tb_pc_unit;

  localparam logic [7:0] EN    = 8'h80;
  localparam logic [7:0] START = 8'h40;
  localparam logic [7:0] MODE  = 8'h20;
  localparam logic [7:0] STEP  = 8'h10;
  localparam logic [7:0] STALL = 8'h08;
  localparam logic [7:0] HALT  = 8'h04;
  localparam logic [7:0] BR    = 8'h02;
  localparam logic [7:0] JMP   = 8'h01;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] STP  = 2'b10;
  localparam logic [1:0] HLT  = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] plus;
    logic        valid;
    logic        halted;
    logic [1:0]  st;
    logic        err;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] ba;
    logic [31:0] ja;
    logic [31:0] pc;
    logic        valid;
    logic [1:0]  st;
    logic        err;
    logic [31:0] cnt;
  } vec_t;

  logic        clk, rst;
  logic        en, start, mode, step, stall, halt, br, jmp;
  logic [31:0] br_addr, jmp_addr;

  logic [31:0] a_pc, a_pc_plus, a_cnt;
  logic        a_valid, a_halted, a_err;
  logic [1:0]  a_state;

  logic [7:0]  b_pc, b_pc_plus;
  logic [2:0]  b_cnt;
  logic        b_valid, b_halted, b_err;
  logic [1:0]  b_state;

  int n_vec = 0;
  int n_bad = 0;

  pc_unit dut_a (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_start       (start),
    .i_mode_step   (mode),
    .i_step        (step),
    .i_stall       (stall),
    .i_halt        (halt),
    .i_branch_taken(br),
    .i_branch_addr (br_addr),
    .i_jump        (jmp),
    .i_jump_addr   (jmp_addr),
    .o_pc          (a_pc),
    .o_pc_plus     (a_pc_plus),
    .o_valid       (a_valid),
    .o_halted      (a_halted),
    .o_addr_err    (a_err),
    .o_state       (a_state),
    .o_fetch_count (a_cnt)
  );

  pc_unit #(
    .SIZE_ADDR_PC(8),
    .PC_STEP     (4),
    .RESET_ADDR  (8'h00),
    .COUNT_WIDTH (3)
  ) dut_b (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_start       (start),
    .i_mode_step   (mode),
    .i_step        (step),
    .i_stall       (stall),
    .i_halt        (halt),
    .i_branch_taken(br),
    .i_branch_addr (br_addr[7:0]),
    .i_jump        (jmp),
    .i_jump_addr   (jmp_addr[7:0]),
    .o_pc          (b_pc),
    .o_pc_plus     (b_pc_plus),
    .o_valid       (b_valid),
    .o_halted      (b_halted),
    .o_addr_err    (b_err),
    .o_state       (b_state),
    .o_fetch_count (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got pc=%h plus=%h valid=%b halted=%b state=%b err=%b cnt=%0d; want pc=%h plus=%h valid=%b halted=%b state=%b err=%b cnt=%0d",
               name, act.pc, act.plus, act.valid, act.halted, act.st, act.err, act.cnt,
               exp.pc, exp.plus, exp.valid, exp.halted, exp.st, exp.err, exp.cnt);
    end
  endtask

  task automatic drive(input logic [7:0] ctl, input logic [31:0] ba, input logic [31:0] ja);
    en       = ctl[7];
    start    = ctl[6];
    mode     = ctl[5];
    step     = ctl[4];
    stall    = ctl[3];
    halt     = ctl[2];
    br       = ctl[1];
    jmp      = ctl[0];
    br_addr  = ba;
    jmp_addr = ja;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(8'h00, 32'h0, 32'h0);  // enable low: reset must still win
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Apply one cycle of inputs to both DUTs and check instance A before the edge.
  task automatic vec_a(input string name, input logic [7:0] ctl, input logic [31:0] ba,
                       input logic [31:0] ja, input logic [31:0] pc, input logic v,
                       input logic [1:0] st, input logic e, input logic [31:0] c);
    obs_t act, exp;
    drive(ctl, ba, ja);
    #1;
    act = '{a_pc, a_pc_plus, a_valid, a_halted, a_state, a_err, a_cnt};
    exp = '{pc, pc + 32'd4, v, (st == HLT), st, e, c};
    cmp(name, act, exp);
    tick();
  endtask

  task automatic vec_b(input string name, input logic [7:0] ctl, input logic [31:0] ba,
                       input logic [31:0] ja, input logic [7:0] pc, input logic v,
                       input logic [1:0] st, input logic e, input logic [2:0] c);
    obs_t act, exp;
    logic [7:0] plus;
    drive(ctl, ba, ja);
    #1;
    plus = pc + 8'd4;
    act = '{{24'd0, b_pc}, {24'd0, b_pc_plus}, b_valid, b_halted, b_state, b_err,
            {29'd0, b_cnt}};
    exp = '{{24'd0, pc}, {24'd0, plus}, v, (st == HLT), st, e, {29'd0, c}};
    cmp(name, act, exp);
    tick();
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{EN | START,            32'h0,   32'h0,   32'h00,  1'b0, IDLE, 1'b0, 32'd0};
    vecs[1]  = '{EN,                    32'h0,   32'h0,   32'h00,  1'b1, RUN,  1'b0, 32'd0};
    vecs[2]  = '{EN,                    32'h0,   32'h0,   32'h04,  1'b1, RUN,  1'b0, 32'd1};
    vecs[3]  = '{EN,                    32'h0,   32'h0,   32'h08,  1'b1, RUN,  1'b0, 32'd2};
    vecs[4]  = '{EN,                    32'h0,   32'h0,   32'h0C,  1'b1, RUN,  1'b0, 32'd3};
    vecs[5]  = '{EN,                    32'h0,   32'h0,   32'h10,  1'b1, RUN,  1'b0, 32'd4};
    vecs[6]  = '{EN | JMP,              32'h0,   32'h10,  32'h14,  1'b1, RUN,  1'b0, 32'd5};
    vecs[7]  = '{EN | STALL,            32'h0,   32'h0,   32'h10,  1'b0, RUN,  1'b0, 32'd6};
    vecs[8]  = '{EN | STALL,            32'h0,   32'h0,   32'h10,  1'b0, RUN,  1'b0, 32'd6};
    vecs[9]  = '{EN,                    32'h0,   32'h0,   32'h10,  1'b1, RUN,  1'b0, 32'd6};
    vecs[10] = '{EN | JMP,              32'h0,   32'h20,  32'h14,  1'b1, RUN,  1'b0, 32'd7};
    vecs[11] = '{EN | BR | JMP | STALL, 32'h100, 32'h200, 32'h20,  1'b1, RUN,  1'b0, 32'd8};
    vecs[12] = '{START | MODE | BR,     32'h300, 32'h0,   32'h100, 1'b0, RUN,  1'b0, 32'd9};
    vecs[13] = '{STALL | STEP,          32'h0,   32'h0,   32'h100, 1'b0, RUN,  1'b0, 32'd9};
    vecs[14] = '{EN | START | MODE,     32'h0,   32'h0,   32'h100, 1'b1, RUN,  1'b0, 32'd9};
    vecs[15] = '{EN | HALT | BR,        32'h400, 32'h0,   32'h104, 1'b0, RUN,  1'b0, 32'd10};
    vecs[16] = '{EN | START | BR | JMP, 32'h500, 32'h600, 32'h104, 1'b0, HLT,  1'b0, 32'd10};
    vecs[17] = '{EN,                    32'h0,   32'h0,   32'h104, 1'b0, HLT,  1'b0, 32'd10};

    rst = 1'b1;
    drive(8'h00, 32'h0, 32'h0);
    do_reset();

    // Run mode: increment, stall, redirect priority, enable freeze, halt.
    for (int i = 0; i < 18; i++) begin
      vec_a($sformatf("run[%0d]", i), vecs[i].ctl, vecs[i].ba, vecs[i].ja, vecs[i].pc,
            vecs[i].valid, vecs[i].st, vecs[i].err, vecs[i].cnt);
    end

    // Single-step: a stalled step stays pending, pulses collapse.
    do_reset();
    vec_a("step_start",    EN | START | MODE,  0, 0, 32'h00, 1'b0, IDLE, 1'b0, 0);
    vec_a("step_idle",     EN,                 0, 0, 32'h00, 1'b0, STP,  1'b0, 0);
    vec_a("step_stall1",   EN | STEP | STALL,  0, 0, 32'h00, 1'b0, STP,  1'b0, 0);
    vec_a("step_stall2",   EN | STALL,         0, 0, 32'h00, 1'b0, STP,  1'b0, 0);
    vec_a("step_stall3",   EN | STALL,         0, 0, 32'h00, 1'b0, STP,  1'b0, 0);
    vec_a("step_release",  EN,                 0, 0, 32'h00, 1'b1, STP,  1'b0, 0);
    vec_a("step_once",     EN,                 0, 0, 32'h04, 1'b0, STP,  1'b0, 1);
    vec_a("step_no_extra", EN,                 0, 0, 32'h04, 1'b0, STP,  1'b0, 1);
    vec_a("step_pulse_a",  EN | STEP,          0, 0, 32'h04, 1'b1, STP,  1'b0, 1);
    vec_a("step_pulse_b",  EN | STEP,          0, 0, 32'h08, 1'b1, STP,  1'b0, 2);
    vec_a("step_two_done", EN,                 0, 0, 32'h0C, 1'b0, STP,  1'b0, 3);
    vec_a("collapse_1",    EN | STEP | STALL,  0, 0, 32'h0C, 1'b0, STP,  1'b0, 3);
    vec_a("collapse_2",    EN | STEP | STALL,  0, 0, 32'h0C, 1'b0, STP,  1'b0, 3);
    vec_a("collapse_go",   EN,                 0, 0, 32'h0C, 1'b1, STP,  1'b0, 3);
    vec_a("collapse_done", EN,                 0, 0, 32'h10, 1'b0, STP,  1'b0, 4);

    // Misaligned jump traps into HALTED; only reset recovers.
    do_reset();
    vec_a("mis_start",  EN | START,        0, 0,      32'h00, 1'b0, IDLE, 1'b0, 0);
    vec_a("mis_jump",   EN | JMP,          0, 32'h102, 32'h00, 1'b0, RUN,  1'b0, 0);
    vec_a("mis_halted", EN | START | STEP, 0, 0,      32'h00, 1'b0, HLT,  1'b1, 0);
    vec_a("mis_hold",   EN,                0, 0,      32'h00, 1'b0, HLT,  1'b1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_a("mis_reset",  EN,                0, 0,      32'h00, 1'b0, IDLE, 1'b0, 0);

    // 8-bit PC wraps; enable low freezes; 3-bit counter saturates.
    do_reset();
    vec_b("b_start",  EN | START,  0,     0,     8'h00, 1'b0, IDLE, 1'b0, 3'd0);
    vec_b("b_jump",   EN | JMP,    0,     32'hFC, 8'h00, 1'b1, RUN,  1'b0, 3'd0);
    vec_b("b_wrap",   EN,          0,     0,     8'hFC, 1'b1, RUN,  1'b0, 3'd1);
    vec_b("b_frz0",   8'h00,       0,     0,     8'h00, 1'b0, RUN,  1'b0, 3'd2);
    vec_b("b_frz1",   STALL | BR,  32'h40, 0,     8'h00, 1'b0, RUN,  1'b0, 3'd2);
    vec_b("b_frz2",   HALT,        0,     0,     8'h00, 1'b0, RUN,  1'b0, 3'd2);
    vec_b("b_resume", EN,          0,     0,     8'h00, 1'b1, RUN,  1'b0, 3'd2);
    vec_b("b_c3",     EN,          0,     0,     8'h04, 1'b1, RUN,  1'b0, 3'd3);
    vec_b("b_c4",     EN,          0,     0,     8'h08, 1'b1, RUN,  1'b0, 3'd4);
    vec_b("b_c5",     EN,          0,     0,     8'h0C, 1'b1, RUN,  1'b0, 3'd5);
    vec_b("b_c6",     EN,          0,     0,     8'h10, 1'b1, RUN,  1'b0, 3'd6);
    vec_b("b_c7",     EN,          0,     0,     8'h14, 1'b1, RUN,  1'b0, 3'd7);
    vec_b("b_sat1",   EN,          0,     0,     8'h18, 1'b1, RUN,  1'b0, 3'd7);
    vec_b("b_sat2",   EN,          0,     0,     8'h1C, 1'b1, RUN,  1'b0, 3'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
